// File: rtl/munoc_tid_request_gate.sv
// Request issue gate: holds one request and releases it only when every
// outstanding request of the same TID targets the same destination.
module munoc_tid_request_gate #(
  parameter int BW_TID        = 4,
  parameter int BW_DEST       = 2,
  parameter int BW_PAYLOAD    = 32,
  parameter int NUM_ENTRY     = 4,
  parameter int MAX_PER_ENTRY = 7
) (
  input  logic                  clk,
  input  logic                  rstnn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [BW_TID-1:0]     req_tid,
  input  logic [BW_DEST-1:0]    req_dest,
  input  logic [BW_PAYLOAD-1:0] req_payload,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [BW_TID-1:0]     out_tid,
  output logic [BW_DEST-1:0]    out_dest,
  output logic [BW_PAYLOAD-1:0] out_payload,
  input  logic                  rsp_done,
  input  logic [BW_TID-1:0]     rsp_tid,
  output logic                  busy,
  output logic                  err_unexpected_rsp
);

  localparam int CNT_W = $clog2(MAX_PER_ENTRY + 1);
  localparam int IDX_W = (NUM_ENTRY > 1) ? $clog2(NUM_ENTRY) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_PER_ENTRY);

  logic                  hold_vld;
  logic [BW_TID-1:0]     hold_tid;
  logic [BW_DEST-1:0]    hold_dest;
  logic [BW_PAYLOAD-1:0] hold_payload;

  logic [NUM_ENTRY-1:0]  ent_vld;
  logic [BW_TID-1:0]     ent_tid  [NUM_ENTRY];
  logic [BW_DEST-1:0]    ent_dest [NUM_ENTRY];
  logic [CNT_W-1:0]      ent_cnt  [NUM_ENTRY];

  logic [NUM_ENTRY-1:0]  vld_nxt;
  logic [CNT_W-1:0]      cnt_nxt  [NUM_ENTRY];
  logic [NUM_ENTRY-1:0]  ent_inc, ent_dec, ent_alloc;

  logic                  match_hit, free_hit, rsp_hit;
  logic [IDX_W-1:0]      match_idx, free_idx, rsp_idx;
  logic                  allow, fire, accept, err_q;

  // Saturating up/down step; simultaneous inc and dec cancel out.
  function automatic logic [CNT_W-1:0] cnt_update(input logic [CNT_W-1:0] cnt,
                                                  input logic inc, input logic dec);
    logic [CNT_W-1:0] res;
    res = cnt;
    if (inc && !dec && cnt != CNT_MAX)
      res = cnt + CNT_W'(1);
    else if (dec && !inc && cnt != '0)
      res = cnt - CNT_W'(1);
    return res;
  endfunction

  // Descending scan so the lowest index wins for the free-entry search.
  always_comb begin
    match_hit = 1'b0;
    match_idx = '0;
    free_hit  = 1'b0;
    free_idx  = '0;
    rsp_hit   = 1'b0;
    rsp_idx   = '0;
    for (int i = NUM_ENTRY - 1; i >= 0; i--) begin
      if (ent_vld[i] && ent_tid[i] == hold_tid) begin
        match_hit = 1'b1;
        match_idx = IDX_W'(i);
      end
      if (!ent_vld[i]) begin
        free_hit = 1'b1;
        free_idx = IDX_W'(i);
      end
      if (ent_vld[i] && ent_tid[i] == rsp_tid) begin
        rsp_hit = 1'b1;
        rsp_idx = IDX_W'(i);
      end
    end
  end

  assign allow = match_hit ? (ent_dest[match_idx] == hold_dest && ent_cnt[match_idx] < CNT_MAX)
                           : free_hit;
  assign out_valid   = hold_vld & allow;
  assign fire        = out_valid & out_ready;
  assign req_ready   = ~hold_vld | fire;
  assign accept      = req_valid & req_ready;
  assign out_tid     = hold_tid;
  assign out_dest    = hold_dest;
  assign out_payload = hold_payload;
  assign busy        = hold_vld | (|ent_vld);
  assign err_unexpected_rsp = err_q;

  always_comb begin
    vld_nxt = ent_vld;
    for (int i = 0; i < NUM_ENTRY; i++) begin
      ent_inc[i]   = fire & match_hit & (match_idx == IDX_W'(i));
      ent_alloc[i] = fire & ~match_hit & (free_idx == IDX_W'(i));
      ent_dec[i]   = rsp_done & rsp_hit & (rsp_idx == IDX_W'(i));
      cnt_nxt[i]   = ent_cnt[i];
      if (ent_alloc[i]) begin
        vld_nxt[i] = 1'b1;
        cnt_nxt[i] = CNT_W'(1);
      end else if (ent_vld[i]) begin
        cnt_nxt[i] = cnt_update(ent_cnt[i], ent_inc[i], ent_dec[i]);
        vld_nxt[i] = (cnt_nxt[i] != '0);
      end
    end
  end

  // Stage boundary: control state (hold occupancy, entry validity and counts).
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      hold_vld <= 1'b0;
      ent_vld  <= '0;
      err_q    <= 1'b0;
      for (int i = 0; i < NUM_ENTRY; i++)
        ent_cnt[i] <= '0;
    end else begin
      if (accept)
        hold_vld <= 1'b1;
      else if (fire)
        hold_vld <= 1'b0;
      ent_vld <= vld_nxt;
      err_q   <= rsp_done & ~rsp_hit;
      for (int i = 0; i < NUM_ENTRY; i++)
        ent_cnt[i] <= cnt_nxt[i];
    end
  end

  // Stage boundary: data fields, qualified by the control valids above.
  always_ff @(posedge clk) begin
    if (accept) begin
      hold_tid     <= req_tid;
      hold_dest    <= req_dest;
      hold_payload <= req_payload;
    end
    for (int i = 0; i < NUM_ENTRY; i++) begin
      if (ent_alloc[i]) begin
        ent_tid[i]  <= hold_tid;
        ent_dest[i] <= hold_dest;
      end
    end
  end

endmodule

// File: tb/tb_munoc_tid_request_gate.sv
// Directed bench for munoc_tid_request_gate with an in-order request scoreboard.
module tb_munoc_tid_request_gate;

  logic        clk = 1'b0;
  logic        rstnn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_tid = '0;
  logic [1:0]  req_dest = '0;
  logic [31:0] req_payload = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [3:0]  out_tid;
  logic [1:0]  out_dest;
  logic [31:0] out_payload;
  logic        rsp_done = 1'b0;
  logic [3:0]  rsp_tid = '0;
  logic        busy;
  logic        err_unexpected_rsp;

  int compared = 0;
  int failed   = 0;

  typedef struct packed {
    logic [3:0]  tid;
    logic [1:0]  dest;
    logic [31:0] payload;
  } req_t;

  req_t sb_q[$];
  req_t mon_exp;

  munoc_tid_request_gate #(
    .BW_TID(4), .BW_DEST(2), .BW_PAYLOAD(32), .NUM_ENTRY(4), .MAX_PER_ENTRY(7)
  ) dut (
    .clk(clk), .rstnn(rstnn),
    .req_valid(req_valid), .req_ready(req_ready), .req_tid(req_tid),
    .req_dest(req_dest), .req_payload(req_payload),
    .out_valid(out_valid), .out_ready(out_ready), .out_tid(out_tid),
    .out_dest(out_dest), .out_payload(out_payload),
    .rsp_done(rsp_done), .rsp_tid(rsp_tid),
    .busy(busy), .err_unexpected_rsp(err_unexpected_rsp)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, observed hang, required completion");
    $fatal(1, "timeout");
  end

  // Inputs change 1 time unit after posedge, so negedge sees the values the next edge uses.
  always @(negedge clk) begin
    if (rstnn && out_valid && out_ready) begin
      compared++;
      if (sb_q.size() == 0) begin
        failed++;
        $error("FAIL sb_fire: observed fire tid=%0h, required no pending request", out_tid);
      end else begin
        mon_exp = sb_q.pop_front();
        assert ({out_tid, out_dest, out_payload} === mon_exp) else begin
          failed++;
          $error("FAIL sb_data: observed %0h required %0h", {out_tid, out_dest, out_payload}, mon_exp);
        end
      end
    end
    if (rstnn && req_valid && req_ready)
      sb_q.push_back({req_tid, req_dest, req_payload});
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [3:0] t, input logic [1:0] d);
    int n;
    n = 0;
    req_valid   = 1'b1;
    req_tid     = t;
    req_dest    = d;
    req_payload = $urandom;
    while (!req_ready && n < 50) begin
      cyc();
      n++;
    end
    chk("send_ready", {63'd0, req_ready}, 64'd1);
    cyc();
    req_valid = 1'b0;
  endtask

  task automatic rsp(input logic [3:0] t);
    rsp_done = 1'b1;
    rsp_tid  = t;
    cyc();
    rsp_done = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (3) cyc();
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_err", {63'd0, err_unexpected_rsp}, 64'd0);
    rstnn = 1'b1;
    cyc();
    chk("rst_req_ready", {63'd0, req_ready}, 64'd1);

    // Single request, 1-cycle latency, entry0 allocated
    send(4'd3, 2'd1);
    chk("t1_out_valid", {63'd0, out_valid}, 64'd1);
    chk("t1_out_tid", {60'd0, out_tid}, 64'd3);
    chk("t1_out_dest", {62'd0, out_dest}, 64'd1);
    chk("t1_busy", {63'd0, busy}, 64'd1);
    cyc();
    chk("t1_ent_vld", {60'd0, dut.ent_vld}, 64'h1);
    chk("t1_ent_tid", {60'd0, dut.ent_tid[0]}, 64'd3);
    chk("t1_ent_dest", {62'd0, dut.ent_dest[0]}, 64'd1);
    chk("t1_ent_cnt", {61'd0, dut.ent_cnt[0]}, 64'd1);
    rsp(4'd3);
    chk("t1_drained", {63'd0, busy}, 64'd0);

    // Per-entry limit of 7 outstanding
    for (int k = 0; k < 8; k++) send(4'd3, 2'd1);
    chk("t2_cnt_max", {61'd0, dut.ent_cnt[0]}, 64'd7);
    chk("t2_blocked", {63'd0, out_valid}, 64'd0);
    chk("t2_req_ready", {63'd0, req_ready}, 64'd0);
    cyc();
    chk("t2_still_blocked", {63'd0, out_valid}, 64'd0);
    rsp(4'd3);
    chk("t2_released", {63'd0, out_valid}, 64'd1);
    cyc();
    chk("t2_cnt_back", {61'd0, dut.ent_cnt[0]}, 64'd7);
    for (int k = 0; k < 7; k++) rsp(4'd3);
    chk("t2_empty", {60'd0, dut.ent_vld}, 64'h0);

    // Same TID, different dest, freed in the blocked cycle
    send(4'd3, 2'd1);
    cyc();
    send(4'd3, 2'd2);
    chk("t3_blocked", {63'd0, out_valid}, 64'd0);
    rsp_done = 1'b1;
    rsp_tid  = 4'd3;
    #1;
    chk("t3_blocked_same_cycle", {63'd0, out_valid}, 64'd0);
    cyc();
    rsp_done = 1'b0;
    chk("t3_allowed_next", {63'd0, out_valid}, 64'd1);
    cyc();
    chk("t3_realloc_dest", {62'd0, dut.ent_dest[0]}, 64'd2);
    chk("t3_realloc_cnt", {61'd0, dut.ent_cnt[0]}, 64'd1);
    rsp(4'd3);

    // Full table, lowest free entry reused
    for (int k = 0; k < 4; k++) send(4'(k), 2'd0);
    send(4'd5, 2'd0);
    chk("t4_full", {60'd0, dut.ent_vld}, 64'hf);
    chk("t4_blocked", {63'd0, out_valid}, 64'd0);
    cyc();
    chk("t4_still_blocked", {63'd0, out_valid}, 64'd0);
    rsp(4'd2);
    chk("t4_freed", {60'd0, dut.ent_vld}, 64'hb);
    chk("t4_allowed", {63'd0, out_valid}, 64'd1);
    cyc();
    chk("t4_alloc_tid", {60'd0, dut.ent_tid[2]}, 64'd5);
    chk("t4_full_again", {60'd0, dut.ent_vld}, 64'hf);
    rsp(4'd0);
    rsp(4'd1);
    rsp(4'd3);

    // Unexpected response
    rsp_done = 1'b1;
    rsp_tid  = 4'd9;
    #1;
    chk("t5_err_before", {63'd0, err_unexpected_rsp}, 64'd0);
    cyc();
    rsp_done = 1'b0;
    chk("t5_err_pulse", {63'd0, err_unexpected_rsp}, 64'd1);
    chk("t5_table_vld", {60'd0, dut.ent_vld}, 64'h4);
    chk("t5_table_cnt", {61'd0, dut.ent_cnt[2]}, 64'd1);
    cyc();
    chk("t5_err_clear", {63'd0, err_unexpected_rsp}, 64'd0);
    rsp(4'd5);
    chk("t5_idle", {63'd0, busy}, 64'd0);

    // Fire and response together on a count-1 entry
    send(4'd7, 2'd3);
    cyc();
    send(4'd7, 2'd3);
    chk("t6_valid", {63'd0, out_valid}, 64'd1);
    rsp_done = 1'b1;
    rsp_tid  = 4'd7;
    cyc();
    rsp_done = 1'b0;
    chk("t6_ent_vld", {60'd0, dut.ent_vld}, 64'h1);
    chk("t6_ent_cnt", {61'd0, dut.ent_cnt[0]}, 64'd1);

    // Asynchronous reset mid-stream
    out_ready = 1'b0;
    send(4'd8, 2'd0);
    chk("t7_held", {63'd0, out_valid}, 64'd1);
    cyc();
    rstnn = 1'b0;
    sb_q.delete();
    #1;
    chk("t7_rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("t7_rst_busy", {63'd0, busy}, 64'd0);
    cyc();
    rstnn = 1'b1;
    out_ready = 1'b1;
    cyc();
    chk("t7_post_ready", {63'd0, req_ready}, 64'd1);
    send(4'd1, 2'd1);
    cyc();
    chk("t7_post_alloc", {60'd0, dut.ent_tid[0]}, 64'd1);
    chk("t7_post_vld", {60'd0, dut.ent_vld}, 64'h1);
    chk("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
